onewire_ds18b20_slave: RTL and testbench
========================================

// Module: onewire_ds18b20_slave
// PURPOSE
//  1-Wire responder emulating a DS18B20 (skip-ROM subset). Answers the thermometer master's
//  reset, ROM 0xCC, function 0x44 (convert) and 0xBE (read scratchpad). Temperature comes
//  from temp_in. Used as the bus partner of the thermometer master in sim and on a second GPIO.
// PARAMETERS
//  CLK_MHZ        27   clk ticks per microsecond; every *_US value is multiplied by it
//  T_RST_MIN_US   480  minimum low time accepted as a bus reset
//  T_PD_WAIT_US   30   delay from reset-release rising edge to presence pulse
//  T_PD_LOW_US    120  presence pulse low time
//  T_SAMPLE_US    30   write-slot sample point after the falling edge
//  T_RD_HOLD_US   30   low hold after the falling edge when a 0 bit is sent
// PORTS
//  clk        in   1   system clock (CLOCK_27)
//  rst        in   1   asynchronous, active-high reset
//  dq_in      in   1   raw bus level (async; synchronised internally)
//  dq_pull    out  1   1 = drive bus low; top level maps it to open-drain
//  temp_in    in   16  DS18B20-format temperature (1/16 degC, two's complement)
//  conv_pulse out  1   one-cycle strobe when 0x44 is accepted
//  cmd_err    out  1   one-cycle strobe on an unsupported ROM or function byte
//  busy       out  1   high from presence start until DONE or IDLE
// BEHAVIOUR
//  - Reset values: dq_pull=0, conv_pulse=0, cmd_err=0, busy=0, state=IDLE, shadow=16'h0550.
//  - dq_in passes through a 2-FF synchroniser; a falling or rising edge is seen 2 clocks late.
//  - One low-time counter runs while the line is low, in every state.
//    On a rising edge with count >= T_RST_MIN: go to PD_WAIT from ANY state. This aborts
//    TX/RX, clears the bit and byte counters, and forces dq_pull=0.
//  - PD_WAIT: wait T_PD_WAIT_US -> PD_LOW.
//  - PD_LOW: dq_pull=1 for T_PD_LOW_US -> ROM_CMD.
//  - ROM_CMD / FUNC_CMD: each falling edge opens a slot. Sample the bus T_SAMPLE_US later and
//    shift the bit in LSB first. Edges inside an open slot are ignored.
//  - Decode after the 8th bit. ROM 0xCC -> FUNC_CMD.
//  - FUNC 0x44 -> shadow<=temp_in, conv_pulse for 1 cycle -> DONE.
//  - FUNC 0xBE -> TX with the byte pointer at 0.
//  - Any other byte -> cmd_err for 1 cycle -> DONE.
//  - TX: on each falling edge, take the current bit LSB first.
//    Bit=0: dq_pull=1 from the detected edge for T_RD_HOLD_US, then release. Bit=1: leave released.
//    Advance the bit after the hold window ends.
//  - TX source without the macro: shadow[7:0], then shadow[15:8]. After 16 bits -> DONE.
//  - DONE: line released; all slots read as 1; only a bus reset leaves it.
//  - shadow holds across bus resets; only rst or a 0x44 changes it.
//  - rst mid-presence or mid-hold releases the line immediately (async).
//  - Counters are wide enough for (T_RST_MIN_US+1)*CLK_MHZ and saturate; no wrap.
// CONFIGURATION
//  ONEWIRE_SLAVE_CRC_EN defined: TX sends the full 9-byte scratchpad:
//    shadow LSB, shadow MSB, 4B, 46, 7F, FF, 0C, 10, CRC8.
//    CRC8 is Dallas x^8+x^5+x^4+1, LSB-first, init 0, computed serially over bytes 0-7 as sent.
//    After 72 bits -> DONE.
//  Undefined: 2-byte TX only; no CRC logic is synthesised.
// TESTING
//  1 Bus low 480us, then release -> dq_pull rises 30us (+2 clk) after release and stays high
//    120us; busy=1.
//  2 Bus low 400us, then release -> no presence; state unchanged.
//  3 Reset, write CC, write 44 with temp_in=16'h0191 -> conv_pulse one cycle after the 16th
//    sample. Then reset, CC, BE, 16 read slots -> bits read 16'h0191 LSB first; a 0 bit reads
//    low 30us.
//  4 Reset, write 33 -> cmd_err pulse; following 8 read slots all return 1; no dq_pull.
//  5 Reset mid-TX after bit 5 (low 500us) -> presence follows; CC BE restarts from bit 0.
//  6 CRC_EN, after rst, no convert: reset, CC, BE, 72 slots -> 50 05 4B 46 7F FF 0C 10 1C.

Source files
------------

// File: rtl/onewire_ds18b20_slave.sv
`timescale 1ns/1ps
// onewire_ds18b20_slave: DS18B20 skip-ROM responder (reset/presence, CC, 44, BE).
// Define ONEWIRE_SLAVE_CRC_EN to send the full 9-byte scratchpad with CRC8.
module onewire_ds18b20_slave #(
  parameter int CLK_MHZ      = 27,
  parameter int T_RST_MIN_US = 480,
  parameter int T_PD_WAIT_US = 30,
  parameter int T_PD_LOW_US  = 120,
  parameter int T_SAMPLE_US  = 30,
  parameter int T_RD_HOLD_US = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dq_in,
  output logic        dq_pull,
  input  logic [15:0] temp_in,
  output logic        conv_pulse,
  output logic        cmd_err,
  output logic        busy
);

  localparam int CW = $clog2((T_RST_MIN_US + 1) * CLK_MHZ + 1);
  localparam logic [CW-1:0] RST_C = CW'(T_RST_MIN_US * CLK_MHZ);
  localparam logic [CW-1:0] SAT_C = CW'((T_RST_MIN_US + 1) * CLK_MHZ);
  localparam logic [CW-1:0] PDW_C = CW'(T_PD_WAIT_US * CLK_MHZ - 1);
  localparam logic [CW-1:0] PDL_C = CW'(T_PD_LOW_US * CLK_MHZ - 1);
  localparam logic [CW-1:0] SMP_C = CW'(T_SAMPLE_US * CLK_MHZ - 1);
  localparam logic [CW-1:0] HLD_C = CW'(T_RD_HOLD_US * CLK_MHZ - 1);
`ifdef ONEWIRE_SLAVE_CRC_EN
  localparam int BW = 7;
  localparam logic [BW-1:0] LAST_BIT = 7'd71;
`else
  localparam int BW = 4;
  localparam logic [BW-1:0] LAST_BIT = 4'd15;
`endif

  typedef enum logic [2:0] {
    IDLE, PD_WAIT, PD_LOW, ROM_CMD, FUNC_CMD, TX, DONE
  } state_t;

  state_t        state_q;
  logic          s1_q, s2_q, prev_q;
  logic [CW-1:0] low_q, cnt_q;
  logic          slot_q;
  logic [6:0]    sh_q;
  logic [2:0]    nb_q;
  logic [BW-1:0] bit_q;
  logic [15:0]   shadow_q;
  logic          pull_q, conv_q, err_q, busy_q;
  logic          fall, rise, bus_rst, rom, tx_bit;
  logic [7:0]    rx_byte;

  assign fall    = prev_q & ~s2_q;
  assign rise    = ~prev_q & s2_q;
  assign bus_rst = rise && (low_q >= RST_C);
  assign rom     = (state_q == ROM_CMD);
  assign rx_byte = {s2_q, sh_q};

`ifdef ONEWIRE_SLAVE_CRC_EN
  logic [7:0] crc_q, crc_d, tx_byte;

  always_comb begin
    unique case (bit_q[6:3])
      4'd0:    tx_byte = shadow_q[7:0];
      4'd1:    tx_byte = shadow_q[15:8];
      4'd2:    tx_byte = 8'h4B;
      4'd3:    tx_byte = 8'h46;
      4'd4:    tx_byte = 8'h7F;
      4'd5:    tx_byte = 8'hFF;
      4'd6:    tx_byte = 8'h0C;
      4'd7:    tx_byte = 8'h10;
      default: tx_byte = crc_q;
    endcase
  end

  assign tx_bit = tx_byte[bit_q[2:0]];
  assign crc_d  = {1'b0, crc_q[7:1]}
                ^ ((crc_q[0] ^ tx_bit) ? 8'h8C : 8'h00);
`else
  assign tx_bit = shadow_q[bit_q];
`endif

  // Sync idles high so a reset release never fakes a bus edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
      low_q  <= '0;
    end else begin
      s1_q   <= dq_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      if (s2_q)
        low_q <= '0;
      else if (low_q != SAT_C)
        low_q <= low_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      slot_q   <= 1'b0;
      sh_q     <= '0;
      nb_q     <= '0;
      bit_q    <= '0;
      shadow_q <= 16'h0550;
      pull_q   <= 1'b0;
      conv_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef ONEWIRE_SLAVE_CRC_EN
      crc_q    <= '0;
`endif
    end else begin
      conv_q <= 1'b0;
      err_q  <= 1'b0;
      if (cnt_q != '1)
        cnt_q <= cnt_q + CW'(1);
      if (bus_rst) begin
        state_q <= PD_WAIT;
        cnt_q   <= '0;
        slot_q  <= 1'b0;
        nb_q    <= '0;
        bit_q   <= '0;
        pull_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          PD_WAIT: if (cnt_q == PDW_C) begin
            state_q <= PD_LOW;
            cnt_q   <= '0;
            pull_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
          PD_LOW: if (cnt_q == PDL_C) begin
            state_q <= ROM_CMD;
            pull_q  <= 1'b0;
          end
          ROM_CMD, FUNC_CMD: begin
            if (!slot_q) begin
              if (fall) begin
                slot_q <= 1'b1;
                cnt_q  <= '0;
              end
            end else if (cnt_q == SMP_C) begin
              slot_q <= 1'b0;
              sh_q   <= rx_byte[7:1];
              nb_q   <= nb_q + 3'd1;
              if (nb_q == 3'd7) begin
                unique case (1'b1)
                  rom && rx_byte == 8'hCC: state_q <= FUNC_CMD;
                  !rom && rx_byte == 8'h44: begin
                    shadow_q <= temp_in;
                    conv_q   <= 1'b1;
                    state_q  <= DONE;
                    busy_q   <= 1'b0;
                  end
                  !rom && rx_byte == 8'hBE: begin
                    state_q <= TX;
                    bit_q   <= '0;
`ifdef ONEWIRE_SLAVE_CRC_EN
                    crc_q   <= '0;
`endif
                  end
                  default: begin
                    err_q   <= 1'b1;
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                  end
                endcase
              end
            end
          end
          TX: begin
            if (!slot_q) begin
              if (fall) begin
                slot_q <= 1'b1;
                cnt_q  <= '0;
                pull_q <= ~tx_bit;
              end
            end else if (cnt_q == HLD_C) begin
              slot_q <= 1'b0;
              pull_q <= 1'b0;
              bit_q  <= bit_q + BW'(1);
`ifdef ONEWIRE_SLAVE_CRC_EN
              if (!bit_q[6])
                crc_q <= crc_d;
`endif
              if (bit_q == LAST_BIT) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign dq_pull    = pull_q;
  assign conv_pulse = conv_q;
  assign cmd_err    = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_onewire_ds18b20_slave.sv
`timescale 1ns/1ps
// Bench for onewire_ds18b20_slave: transaction-level bus model predicting
// pull windows and strobes, checked every cycle, plus literal read-back checks.
module tb_onewire_ds18b20_slave;

  localparam int CLK  = 2;
  localparam int RSTC = 480 * CLK;
  localparam int WC   = 30 * CLK;
  localparam int LC   = 120 * CLK;
  localparam int SC   = 30 * CLK;
  localparam int HC   = 30 * CLK;
  localparam int P_IDLE = 0, P_ROM = 2, P_FUNC = 3, P_TX = 4, P_DONE = 5;

  typedef struct { int s; int e; } win_t;

  logic clk = 0, rst = 0, drv = 1;
  logic [15:0] temp_in = 16'h0191;
  logic dq_in, dq_pull, conv_pulse, cmd_err, busy;
  assign dq_in = drv & ~dq_pull;

  int cyc = 0, checks = 0, failures = 0, conv_seen = 0, err_seen = 0;
  bit chk_en = 0;
  win_t wins[$];
  int exp_conv[$], exp_err[$];
  int m_phase = P_IDLE, m_nb = 0;
  logic [7:0] m_byte = 8'h00;
  logic [15:0] m_shadow = 16'h0550;
  bit m_tx[$];

  onewire_ds18b20_slave #(.CLK_MHZ(CLK)) dut (
    .clk(clk), .rst(rst), .dq_in(dq_in), .dq_pull(dq_pull),
    .temp_in(temp_in), .conv_pulse(conv_pulse), .cmd_err(cmd_err),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [71:0] act, logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

`ifdef ONEWIRE_SLAVE_CRC_EN
  function automatic logic [7:0] crc8(logic [63:0] d);
    logic [7:0] c;
    bit fb;
    c = 8'h00;
    for (int i = 0; i < 64; i++) begin
      fb = c[0] ^ d[i];
      c = c >> 1;
      if (fb) c = c ^ 8'h8C;
    end
    return c;
  endfunction
`endif

  function automatic void load_tx();
    logic [71:0] d;
    int n;
    m_tx.delete();
    d = '0;
`ifdef ONEWIRE_SLAVE_CRC_EN
    d[63:0] = {8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, m_shadow};
    d[71:64] = crc8(d[63:0]);
    n = 72;
`else
    d[15:0] = m_shadow;
    n = 16;
`endif
    for (int i = 0; i < n; i++) m_tx.push_back(d[i]);
  endfunction

  // Model of one bus falling edge at cycle c with written level w; returns read level.
  function automatic bit model_fall(bit w, int c);
    bit rd;
    rd = 1'b1;
    if (m_phase == P_ROM || m_phase == P_FUNC) begin
      m_byte = {w, m_byte[7:1]};
      m_nb++;
      if (m_nb == 8) begin
        m_nb = 0;
        if (m_phase == P_ROM) begin
          if (m_byte == 8'hCC) m_phase = P_FUNC;
          else begin exp_err.push_back(c + 3 + SC); m_phase = P_DONE; end
        end else if (m_byte == 8'h44) begin
          exp_conv.push_back(c + 3 + SC);
          m_shadow = temp_in;
          m_phase = P_DONE;
        end else if (m_byte == 8'hBE) begin
          m_phase = P_TX;
          load_tx();
        end else begin
          exp_err.push_back(c + 3 + SC);
          m_phase = P_DONE;
        end
      end
    end else if (m_phase == P_TX) begin
      rd = m_tx.pop_front();
      if (!rd) wins.push_back('{c + 3, c + 3 + HC});
      if (m_tx.size() == 0) m_phase = P_DONE;
    end
    return rd;
  endfunction

  always @(negedge clk) begin
    bit ep, ec, ee;
    if (chk_en) begin
      ep = 0; ec = 0; ee = 0;
      foreach (wins[i]) if (cyc >= wins[i].s && cyc < wins[i].e) ep = 1;
      foreach (exp_conv[i]) if (exp_conv[i] == cyc) ec = 1;
      foreach (exp_err[i]) if (exp_err[i] == cyc) ee = 1;
      check("dq_pull", dq_pull, ep);
      check("conv_pulse", conv_pulse, ec);
      check("cmd_err", cmd_err, ee);
      if (conv_pulse) conv_seen++;
      if (cmd_err) err_seen++;
    end
  end

  task automatic wait_cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fall_at(output int c);
    @(negedge clk);
    drv = 0;
    c = cyc;
  endtask

  task automatic bus_reset(int low_us);
    int c, k, m;
    fall_at(c);
    void'(model_fall(1'b0, c));
    wait_cyc(low_us * CLK);
    drv = 1;
    c = cyc;
    if (low_us * CLK >= RSTC) begin
      m_phase = P_ROM;
      m_nb = 0;
      m_tx.delete();
      wins.push_back('{c + 3 + WC, c + 3 + WC + LC});
      k = 0;
      while (!dq_pull && k < 2000) begin @(negedge clk); k++; end
      check("pd_delay", k, 63);
      check("pd_busy", busy, 1);
      m = 0;
      while (dq_pull && m < 2000) begin @(negedge clk); m++; end
      check("pd_width", m, 240);
    end
    wait_cyc(20);
  endtask

  task automatic write_bit(bit w);
    int c;
    fall_at(c);
    void'(model_fall(w, c));
    wait_cyc(w ? 2 * CLK : 60 * CLK);
    drv = 1;
    wait_cyc(w ? 73 * CLK : 15 * CLK);
  endtask

  task automatic write_byte(logic [7:0] b);
    for (int i = 0; i < 8; i++) write_bit(b[i]);
  endtask

  task automatic read_bit(output bit r);
    int c;
    bit e;
    fall_at(c);
    e = model_fall(1'b1, c);
    wait_cyc(2 * CLK);
    drv = 1;
    wait_cyc(13 * CLK);
    r = dq_in;
    check("read_bit", r, e);
    wait_cyc(60 * CLK);
  endtask

  task automatic read_bits(int n, output logic [71:0] v);
    bit r;
    v = '0;
    for (int i = 0; i < n; i++) begin
      read_bit(r);
      v[i] = r;
    end
  endtask

  initial begin
    logic [71:0] v;
    int k;
    #1 rst = 1;
    repeat (3) @(negedge clk);
    check("rst_dq_pull", dq_pull, 0);
    check("rst_conv", conv_pulse, 0);
    check("rst_err", cmd_err, 0);
    check("rst_busy", busy, 0);
    rst = 0;
    chk_en = 1;
    wait_cyc(10);

    bus_reset(480);
    bus_reset(400);
    check("busy_kept", busy, 1);

    temp_in = 16'h0191;
    bus_reset(480);
    write_byte(8'hCC);
    write_byte(8'h44);
    check("conv_count", conv_seen, 1);
    check("busy_done", busy, 0);
    bus_reset(480);
    write_byte(8'hCC);
    write_byte(8'hBE);
    check("busy_tx", busy, 1);
    read_bits(16, v);
    check("rd_0191", v[15:0], 16'h0191);

    bus_reset(480);
    write_byte(8'h33);
    check("err_count", err_seen, 1);
    read_bits(8, v);
    check("rd_after_err", v[7:0], 8'hFF);

    bus_reset(480);
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_bits(5, v);
    check("rd_5bits", v[4:0], 5'h11);
    bus_reset(500);
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_bits(16, v);
    check("rd_restart", v[15:0], 16'h0191);
    check("busy_end", busy, 0);

    fall_at(k);
    void'(model_fall(1'b0, k));
    wait_cyc(RSTC);
    drv = 1;
    k = cyc;
    wins.push_back('{k + 3 + WC, k + 3 + WC + LC});
    wait_cyc(3 + WC + 10);
    check("pd_mid", dq_pull, 1);
    chk_en = 0;
    #2 rst = 1;
    #1;
    check("rst_async_pull", dq_pull, 0);
    check("rst_async_busy", busy, 0);
    wins.delete();
    exp_conv.delete();
    exp_err.delete();
    m_tx.delete();
    m_phase = P_IDLE;
    m_nb = 0;
    m_shadow = 16'h0550;
    @(negedge clk);
    rst = 0;
    chk_en = 1;
    wait_cyc(5);

    bus_reset(480);
    write_byte(8'hCC);
    write_byte(8'hBE);
`ifdef ONEWIRE_SLAVE_CRC_EN
    read_bits(72, v);
    check("rd_scratch", v, 72'h1C100CFF7F464B0550);
`else
    read_bits(17, v);
    check("rd_shadow", v[16:0], 17'h10550);
`endif
    wait_cyc(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
